result_mem_reader: RTL and testbench
====================================

// Module: result_mem_reader
// PURPOSE
//  Drains the product matrix from result memory (Data_Memory3) through its read port (Ar/o_Data).
//  Other end of the write interface (Aw/in_Data/WE) that fills that memory.
//  On start it reads COUNT consecutive words from a base address, wrapping within the memory.
//  Results leave on a valid/ready stream with a last flag, then done pulses once.
// PARAMETERS
//  ADDR_W   7    memory address width; memory depth = 2**ADDR_W words
//  DATA_W   32   memory word / stream data width
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       one-cycle request; sampled only in IDLE
//  base_addr    in   ADDR_W  first word address, latched on accepted start
//  count        in   ADDR_W+1  words to read, 0..2**ADDR_W, latched on accepted start
//  Ar           out  ADDR_W  read address to result memory
//  mem_rd_data  in   DATA_W  memory o_Data; combinational read: valid same cycle as Ar
//  out_data     out  DATA_W  stream data (registered)
//  out_valid    out  1       stream data valid
//  out_ready    in   1       sink accepts when out_valid && out_ready
//  out_last     out  1       high with final word of the transfer
//  busy         out  1       high in READ and DRAIN
//  done         out  1       one-cycle pulse when transfer complete
// BEHAVIOUR
//  Reset: state=IDLE; Ar, out_data, out_valid, out_last, busy, done all 0; internal addr/remaining 0.
//  Reset has priority over every other event and aborts a transfer mid-stream; no done pulse.
//  States: IDLE, READ, DRAIN.
//  IDLE: Ar=0. On start: latch addr<=base_addr, rem<=count.
//    count!=0 -> READ.
//    count==0 -> done=1 next cycle; stay IDLE.
//  READ: Ar=addr. A load happens when the output register is free, i.e. !out_valid || out_ready.
//    On load: out_data<=mem_rd_data; out_valid<=1; out_last<=(rem==1);
//      addr<=addr+1 mod 2**ADDR_W (wraps 127->0); rem<=rem-1.
//    When loading with rem==1 -> DRAIN.
//    No load (output stalled): addr, rem and out_* hold; Ar stays stable.
//  DRAIN: Ar holds last address. On out_valid && out_ready: out_valid<=0, out_last<=0, done<=1, -> IDLE.
//  out_valid, once high, stays high with out_data/out_last stable until handshake.
//  Throughput 1 word/clk with out_ready held high.
//  Latency: start at edge t -> READ at t+1 -> first out_valid at t+2.
//  done pulses the cycle after the final handshake.
//  busy = (state!=IDLE), registered with state.
//  start outside IDLE is ignored, as is any base_addr/count change.
//  start in the same cycle as done is accepted; done has no effect on the new transfer.
//  out_last is never high while out_valid is low.
// TESTING
//  1 Reset: assert rst 2 clks mid-transfer -> all outputs 0, IDLE; next start runs normally.
//  2 Basic: mem[i]=i*3; base=0, count=9 (3x3), out_ready=1 ->
//    out_data 0,3,...,24 on 9 consecutive cycles from t+2; last on 24; done at t+11.
//  3 Backpressure: count=4, out_ready low on alternate cycles ->
//    each word held stable until accepted; no duplicates or drops; Ar stable while stalled.
//  4 Wrap: base=126, count=4 -> Ar sequence 126,127,0,1; data matches mem[126],mem[127],mem[0],mem[1].
//  5 Edge counts: count=0 -> done at t+1 with out_valid never high;
//    count=128, base=5 -> all 128 words in order, last only on mem[4].
//  6 start pulsed while busy -> ignored; start on the done cycle -> second transfer starts cleanly.

Source files
------------

// File: rtl/result_mem_reader.sv
// Streams COUNT words out of result memory starting at a base address.
// Valid/ready output with last flag; done pulses once per completed transfer.
module result_mem_reader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] Ar,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              load;
  logic              hs;

  assign hs   = out_valid_q && out_ready;
  assign load = (state_q == READ) && (!out_valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      ar_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      ar_q        <= ar_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && count != '0) state_d = READ;
      end
      READ: begin
        if (load && rem_q == REM_ONE) state_d = DRAIN;
      end
      DRAIN: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = count;
          done_d = (count == '0);
        end
      end
      READ: begin
        if (load) begin
          out_data_d  = mem_rd_data;
          out_valid_d = 1'b1;
          out_last_d  = (rem_q == REM_ONE);
          addr_d      = addr_q + ADDR_W'(1);
          rem_d       = rem_q - REM_ONE;
        end
      end
      DRAIN: begin
        if (hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
    // Ar tracks the fetch pointer in READ, then freezes on the last word
    unique case (state_d)
      READ:    ar_d = addr_d;
      DRAIN:   ar_d = ar_q;
      default: ar_d = '0;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign Ar        = ar_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_result_mem_reader.sv
// Bench for result_mem_reader: memory model plus word-order reference.
// Expected words come straight from the bench's memory array and count.
module tb_result_mem_reader;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [AW-1:0] ar;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb mem_rd_data = mem[ar];

  result_mem_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .count(count),
    .Ar(ar),
    .mem_rd_data(mem_rd_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ar"}, ar, 0);
  endtask

  // mode: 0 ready always, 1 ready on alternate cycles, 2 random ready
  task automatic run(input int b, input int c, input int mode,
                     input bit pre, input bit poke,
                     input bit chain, input int nb, input int nc);
    int acc = 0;
    int cyc = 0;
    int loaded;
    bit pv = 0;
    bit pr = 0;
    bit pl = 0;
    logic [DW-1:0] pd = '0;
    logic [AW-1:0] pa = '0;
    if (!pre) begin
      start = 1'b1;
      base_addr = AW'(b);
      count = (AW+1)'(c);
    end
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    count = (AW+1)'($urandom);
    if (c == 0) begin
      @(negedge clk);
      chk("zero_done", done, 1);
      idle_chk("zero");
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_done_once", done, 0);
      chk("zero_valid2", out_valid, 0);
      @(posedge clk); #1;
      return;
    end
    while (acc < c && cyc < 4 * c + 20) begin
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = cyc[0];
      else out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      loaded = acc + int'(out_valid);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      if (out_last) chk("last_needs_valid", out_valid, 1);
      if (mode == 0) chk("latency", out_valid, 64'(cyc >= 2));
      if (loaded < c) chk("ar", ar, 64'((b + loaded) % DEPTH));
      else chk("ar_drain", ar, 64'((b + c - 1) % DEPTH));
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_last", out_last, pl);
        chk("hold_ar", ar, pa);
      end
      if (out_valid && out_ready) begin
        chk("data", out_data, mem[(b + acc) % DEPTH]);
        chk("last", out_last, 64'(acc == c - 1));
        acc++;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pl = out_last;
      pa = ar;
      if (poke && cyc == 3) begin
        start = 1'b1;
        base_addr = AW'($urandom);
        count = (AW+1)'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("word_count", acc, c);
    if (mode == 0) chk("throughput", cyc, c + 1);
    if (chain) begin
      start = 1'b1;
      base_addr = AW'(nb);
      count = (AW+1)'(nc);
    end
    @(negedge clk);
    chk("done", done, 1);
    idle_chk("end");
    if (!chain) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_once", done, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle_chk("reset");
    chk("reset_data", out_data, 0);
    chk("reset_done", done, 0);
    @(posedge clk); #1;

    run(0, 9, 0, 0, 0, 0, 0, 0);

    // abort mid-stream
    start = 1'b1;
    base_addr = AW'(10);
    count = (AW+1)'(20);
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("abort");
    chk("abort_data", out_data, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", done, 0);
    @(posedge clk); #1;
    run(3, 5, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    run(40, 4, 1, 0, 0, 0, 0, 0);
    run(126, 4, 0, 0, 0, 0, 0, 0);
    run(0, 0, 0, 0, 0, 0, 0, 0);
    run(5, 128, 2, 0, 0, 0, 0, 0);
    run(100, 6, 0, 0, 1, 0, 0, 0);
    run(60, 5, 2, 0, 0, 1, 120, 12);
    run(120, 12, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      run($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 2,
          0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
